// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Requester ids double as bit positions in the req/gnt vectors.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. On a conflict the requester
// that was not granted last wins; the last-grant register lives in the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_A] && (!req[REQ_B] || (last == REQ_B))) begin
            gnt[REQ_A] = 1'b1;
        end else if (req[REQ_B]) begin
            gnt[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Define MEM_ARB_CLEAR_EN to compile in the post-reset zero-fill sweep (CLEAR state).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              r_run;
    logic              r_last;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_a_pend;
    logic              r_b_pend;
    logic              r_a_rvalid;
    logic              r_b_rvalid;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

`ifdef MEM_ARB_CLEAR_EN
    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CLR_INC  = (ADDR_W+1)'(1);

    state_t          r_state;
    logic [ADDR_W:0] r_clr_addr;
`endif

    assign w_req[REQ_A] = a_req;
    assign w_req[REQ_B] = b_req;

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_pick)
    );

    // The picker is free-running; grants only escape once the controller is live.
    assign w_gnt = r_run ? w_pick : 2'b00;

    always_comb begin
        w_sel_we    = a_we;
        w_sel_addr  = a_addr;
        w_sel_wdata = a_wdata;
        if (w_gnt[REQ_B]) begin
            w_sel_we    = b_we;
            w_sel_addr  = b_addr;
            w_sel_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_last      <= REQ_B;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_a_pend    <= 1'b0;
            r_b_pend    <= 1'b0;
`ifdef MEM_ARB_CLEAR_EN
            r_state     <= CLEAR;
            r_clr_addr  <= '0;
`endif
        end else begin
            r_mem_en <= 1'b0;
            r_a_pend <= 1'b0;
            r_b_pend <= 1'b0;
`ifdef MEM_ARB_CLEAR_EN
            case (r_state)
                CLEAR: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_clr_addr[ADDR_W-1:0];
                    r_mem_wdata <= '0;
                    if (r_clr_addr == CLR_LAST) begin
                        r_state <= RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + CLR_INC;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
`else
            r_run <= 1'b1;
`endif
            // No grant can occur while CLEAR owns the port, since r_run is still low.
            if (w_gnt != 2'b00) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_a_pend    <= w_gnt[REQ_A] & ~w_sel_we;
                r_b_pend    <= w_gnt[REQ_B] & ~w_sel_we;
                r_last      <= w_gnt[REQ_B] ? REQ_B : REQ_A;
            end
        end
    end

    // Read tags trail mem_en by one cycle so rvalid lines up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= r_a_pend;
            r_b_rvalid <= r_b_pend;
        end
    end

    assign a_gnt     = w_gnt[REQ_A];
    assign b_gnt     = w_gnt[REQ_B];
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign rdata     = mem_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef MEM_ARB_CLEAR_EN
    assign busy = (r_state == CLEAR);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Covers both builds; the sweep checks compile only with MEM_ARB_CLEAR_EN.
module tb_mem_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] pre(input int i);
        return DW'((i * 7 + 3) & 255);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

`ifdef MEM_ARB_CLEAR_EN
    task automatic sweep(input int stop_at);
        int errs = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== '0 ||
                mem_addr !== AW'(k) || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) errs++;
            if (k < DEPTH - 1 && (busy !== 1'b1 || a_gnt !== 1'b0 || b_gnt !== 1'b0)) errs++;
            if (k == stop_at) break;
        end
        check_eq("sweep_seq", errs, 0);
        if (stop_at >= DEPTH) check_eq("busy_fall", busy, 1'b0);
    endtask
`endif

    task automatic after_release();
`ifdef MEM_ARB_CLEAR_EN
        sweep(DEPTH);
`else
        @(negedge clk);
        check_eq("busy_zero", busy, 1'b0);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = pre(i);
`ifdef MEM_ARB_CLEAR_EN
            shadow[i] = '0;
`else
            shadow[i] = pre(i);
`endif
        end

        // Reset values, with A already requesting a read of address 5
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mem_en",    mem_en,    1'b0);
        check_eq("rst_mem_we",    mem_we,    1'b0);
        check_eq("rst_mem_addr",  mem_addr,  '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_a_rvalid",  a_rvalid,  1'b0);
        check_eq("rst_b_rvalid",  b_rvalid,  1'b0);
        check_eq("rst_a_gnt",     a_gnt,     1'b0);
`ifdef MEM_ARB_CLEAR_EN
        check_eq("rst_busy", busy, 1'b1);
`else
        check_eq("rst_busy", busy, 1'b0);
`endif

        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("gnt_before_run", a_gnt, 1'b0);
        after_release();
        #1;
        check_eq("first_a_gnt", a_gnt, 1'b1);
        check_eq("first_b_gnt", b_gnt, 1'b0);
        @(negedge clk);
        check_eq("first_mem_en",   mem_en,   1'b1);
        check_eq("first_mem_we",   mem_we,   1'b0);
        check_eq("first_mem_addr", mem_addr, 5);
        a_req = 1'b0;
        @(negedge clk);
        check_eq("first_a_rvalid", a_rvalid, 1'b1);
        check_eq("first_rdata",    rdata,    shadow[5]);
        check_eq("first_b_rvalid", b_rvalid, 1'b0);

        // A writes 0xA5 to 0x3FF, then reads it back
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = AW'(10'h3FF); a_wdata = 8'hA5;
        #1 check_eq("wr_gnt", a_gnt, 1'b1);
        @(negedge clk);
        check_eq("wr_mem_en",    mem_en,    1'b1);
        check_eq("wr_mem_we",    mem_we,    1'b1);
        check_eq("wr_mem_addr",  mem_addr,  10'h3FF);
        check_eq("wr_mem_wdata", mem_wdata, 8'hA5);
        shadow[10'h3FF] = 8'hA5;
        a_we = 1'b0; a_wdata = 8'h00;
        #1 check_eq("rd_gnt", a_gnt, 1'b1);
        @(negedge clk);
        check_eq("rd_mem_we",    mem_we,   1'b0);
        check_eq("rd_early_rv",  a_rvalid, 1'b0);
        a_req = 1'b0;
        @(negedge clk);
        check_eq("rd_a_rvalid",  a_rvalid, 1'b1);
        check_eq("rd_rdata",     rdata,    8'hA5);
        check_eq("rd_b_rvalid",  b_rvalid, 1'b0);
        @(negedge clk);
        check_eq("rd_rvalid_end", a_rvalid, 1'b0);
        check_eq("idle_mem_en",   mem_en,   1'b0);

        // B alone reads 0..7 back-to-back; mem_* holds after the last grant
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 8) begin
                check_eq("b_burst_en",   mem_en,   1'b1);
                check_eq("b_burst_addr", mem_addr, i - 1);
            end
            if (i >= 2) begin
                check_eq("b_burst_rv",    b_rvalid, 1'b1);
                check_eq("b_burst_rdata", rdata,    shadow[i - 2]);
            end
            check_eq("b_burst_a_rv", a_rvalid, 1'b0);
            if (i < 8) begin
                b_req = 1'b1; b_we = 1'b0; b_addr = AW'(i);
                #1 check_eq("b_burst_gnt", b_gnt, 1'b1);
            end else begin
                b_req = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("hold_mem_en",   mem_en,   1'b0);
        check_eq("hold_mem_addr", mem_addr, 7);
        check_eq("hold_b_rvalid", b_rvalid, 1'b0);

        // Reset with a read in flight: no rvalid may ever appear
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(30);
        #1 check_eq("inflight_gnt", a_gnt, 1'b1);
        @(negedge clk);
        check_eq("inflight_en", mem_en, 1'b1);
        rst = 1'b1;
        a_addr = AW'(10); b_req = 1'b1; b_we = 1'b0; b_addr = AW'(20);
        #1;
        check_eq("rst_async_en", mem_en,   1'b0);
        check_eq("rst_async_rv", a_rvalid, 1'b0);
        @(negedge clk);
        check_eq("rst_no_rvalid", a_rvalid, 1'b0);
        check_eq("rst_no_gnt",    a_gnt | b_gnt, 1'b0);
        rst = 1'b0;
`ifdef MEM_ARB_CLEAR_EN
        sweep(500);
        rst = 1'b1;
        #1;
        check_eq("midclr_busy", busy,   1'b1);
        check_eq("midclr_en",   mem_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
`endif
        after_release();

        // Both requesting: A wins the first conflict after reset, then alternate
        for (int i = 0; i < 8; i++) begin
            if (i >= 1 && i <= 6) begin
                check_eq("rr_mem_en",   mem_en,   1'b1);
                check_eq("rr_mem_addr", mem_addr, ((i - 1) % 2 == 0) ? 10 : 20);
            end
            if (i >= 2) begin
                check_eq("rr_a_rvalid", a_rvalid, ((i - 2) % 2 == 0));
                check_eq("rr_b_rvalid", b_rvalid, ((i - 2) % 2 == 1));
                check_eq("rr_rdata",    rdata,    ((i - 2) % 2 == 0) ? shadow[10] : shadow[20]);
            end
            if (i == 6) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            #1;
            if (i < 6) begin
                check_eq("rr_a_gnt", a_gnt, (i % 2 == 0));
                check_eq("rr_b_gnt", b_gnt, (i % 2 == 1));
            end
            @(negedge clk);
        end
        check_eq("rr_drain_a", a_rvalid, 1'b0);
        check_eq("rr_drain_b", b_rvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
